// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback
// for a small RV32-style opcode set, with memory-wait timeout and illegal trap.
// Ports: clk/rst_n; start, halt_req, opcode[6:0], mem_ready in;
//        memory, PC/IR, ALU and writeback controls out; state[2:0]; sticky
//        fault flags illegal and timeout.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt_req,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_src_pc,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       jump,
  output logic [1:0] alu_op,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic            illegal_q, timeout_q;
  logic            set_illegal, set_timeout;
  logic            expired;
  logic            legal;
  state_t          boundary;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD,
      OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
  end

  // Expiry only counts when memory is still not ready; a late ready on the
  // expiry cycle wins and completes the access normally.
  assign expired  = (MEM_TIMEOUT != 0) && (cnt_q == TO_MAX) && !mem_ready;
  assign boundary = halt_req ? S_IDLE : S_FETCH;

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_src_pc  = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_op      = 2'b00;
    alu_src1    = 1'b0;
    alu_src2    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_src_pc = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op_q)
          OP_R:      alu_op = 2'b10;
          OP_I:      begin alu_op = 2'b10; alu_src2 = 1'b1; end
          OP_LUI:    begin alu_op = 2'b11; alu_src2 = 1'b1; end
          OP_AUIPC:  begin alu_op = 2'b00; alu_src1 = 1'b1; alu_src2 = 1'b1; end
          OP_LOAD, OP_STORE: begin
            alu_op   = 2'b00;
            alu_src2 = 1'b1;
            state_d  = S_MEM;
          end
          OP_BRANCH: begin
            alu_op  = 2'b01;
            branch  = 1'b1;
            state_d = boundary;
          end
          OP_JAL:    begin alu_op = 2'b11; alu_src2 = 1'b1; jump = 1'b1; end
          OP_JALR:   begin
            alu_op   = 2'b00;
            alu_src2 = 1'b1;
            branch   = 1'b1;
            jump     = 1'b1;
          end
          default:   state_d = boundary;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
        if (mem_ready) begin
          state_d = (op_q == OP_LOAD) ? S_WB : boundary;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        state_d    = boundary;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 7'd0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      // Counts only while waiting inside a memory phase; any entry or exit
      // leaves it cleared for the next phase.
      if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
        cnt_q <= cnt_q + CW'(1);
      else
        cnt_q <= '0;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule
